// File: rtl/pkt_meta_pkg.sv
// Shared constants for the ingress metadata generator: flit tags, metadata
// bit positions, the config ethertype and the parser FSM encoding.
package pkt_meta_pkg;

  localparam int FLIT_W = 134;
  localparam int META_W = 168;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [15:0] ETH_CONF  = 16'h9005;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  localparam int M_PORT_LSB  = 160;
  localparam int M_LEN_LSB   = 144;
  localparam int M_FLITS_LSB = 128;
  localparam int M_DISCARD   = 118;
  localparam int M_ERROR     = 117;
  localparam int M_CONF      = 116;
  localparam int M_TS_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_meta_gen.sv
// Parses head flits, forwards flits with one cycle of latency and emits packet
// metadata on the tail; drops whole packets when downstream is almost full.
module pkt_meta_gen
  import pkt_meta_pkg::*;
#(
  parameter logic [7:0] P_PORT_ID = 8'd0,
  parameter int         P_TS_W    = 64
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic [47:0]       i_pe_conf_mac,
  input  logic              i_data_valid,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_alf,
  output logic              o_data_valid,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_meta_valid,
  output logic [META_W-1:0] o_meta,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_drop_cnt
);

  state_t state, state_nxt;

  logic [P_TS_W-1:0] ts, ts_lat;
  logic [15:0]       flit_cnt;
  logic              disc_lat, conf_lat;

  logic fwd, emit_meta, trunc, drop_inc, latch;

  logic [1:0]  tag;
  logic        is_head, is_tail, is_conf, is_foreign;
  logic [47:0] dst_mac;

  assign tag        = i_data[133:132];
  assign is_head    = (tag == TAG_HEAD);
  assign is_tail    = (tag == TAG_TAIL);
  assign dst_mac    = i_data[127:80];
  assign is_conf    = (i_data[31:16] == ETH_CONF);
  assign is_foreign = (dst_mac != i_pe_conf_mac) && (dst_mac != MAC_BCAST);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // A head in DROP is treated exactly like a head in IDLE.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    emit_meta = 1'b0;
    trunc     = 1'b0;
    drop_inc  = 1'b0;
    latch     = 1'b0;
    if (i_data_valid) begin
      unique case (state)
        ST_IDLE, ST_DROP: begin
          if (is_head) begin
            if (!i_alf || is_conf) begin
              fwd       = 1'b1;
              latch     = 1'b1;
              state_nxt = ST_FWD;
            end else begin
              drop_inc  = 1'b1;
              state_nxt = ST_DROP;
            end
          end else if (state == ST_IDLE) begin
            drop_inc  = 1'b1;
            state_nxt = is_tail ? ST_IDLE : ST_DROP;
          end else if (is_tail) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FWD: begin
          fwd = 1'b1;
          if (is_head) begin
            trunc     = 1'b1;
            emit_meta = 1'b1;
            state_nxt = ST_DROP;
          end else if (is_tail) begin
            emit_meta = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The closing flit (real tail or truncating head) is counted as the last flit.
  logic [15:0]       flits_tot, len_sat;
  logic [31:0]       len_wide;
  logic [META_W-1:0] meta_nxt;

  assign flits_tot = sat_inc16(flit_cnt);
  assign len_wide  = (({16'd0, flits_tot} - 32'd1) << 4) + {28'd0, i_data[131:128]} + 32'd1;
  assign len_sat   = (len_wide > 32'h0000_FFFF) ? 16'hFFFF : len_wide[15:0];

  always_comb begin
    meta_nxt                        = '0;
    meta_nxt[M_PORT_LSB  +: 8]      = P_PORT_ID;
    meta_nxt[M_LEN_LSB   +: 16]     = len_sat;
    meta_nxt[M_FLITS_LSB +: 16]     = flits_tot;
    meta_nxt[M_DISCARD]             = disc_lat | trunc;
    meta_nxt[M_ERROR]               = trunc;
    meta_nxt[M_CONF]                = conf_lat;
    meta_nxt[M_TS_LSB +: P_TS_W]    = ts_lat;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      ts           <= '0;
      ts_lat       <= '0;
      flit_cnt     <= '0;
      disc_lat     <= 1'b0;
      conf_lat     <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_meta_valid <= 1'b0;
      o_meta       <= '0;
      o_pkt_cnt    <= '0;
      o_drop_cnt   <= '0;
    end else begin
      ts           <= ts + P_TS_W'(1);
      o_data_valid <= fwd;
      o_meta_valid <= emit_meta;
      if (fwd)       o_data <= trunc ? {TAG_TAIL, i_data[131:0]} : i_data;
      if (emit_meta) o_meta <= meta_nxt;
      if (latch) begin
        ts_lat   <= ts;
        disc_lat <= is_foreign;
        conf_lat <= is_conf;
        flit_cnt <= 16'd1;
      end else if (fwd && !emit_meta) begin
        flit_cnt <= flits_tot;
      end
      o_pkt_cnt  <= o_pkt_cnt  + {31'd0, emit_meta};
      o_drop_cnt <= o_drop_cnt + {31'd0, drop_inc};
    end
  end

endmodule

// File: tb/tb_pkt_meta_gen.sv
// Bench for pkt_meta_gen: directed packet table, corner-case sequences and a
// random flit stream, all checked cycle by cycle against a packet-level model.
module tb_pkt_meta_gen;

  localparam logic [47:0]  MAC  = 48'h0200_1122_3344;
  localparam logic [47:0]  BC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0]  FOR  = 48'h0A00_DEAD_BEEF;
  localparam logic [7:0]   PID  = 8'h5A;
  localparam logic [1:0]   H = 2'b01, B = 2'b11, T = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic [133:0] in_dat = '0;
  logic         alf = 1'b0;
  logic         out_vld, meta_vld;
  logic [133:0] out_dat;
  logic [167:0] meta;
  logic [31:0]  pkt_cnt, drop_cnt;

  pkt_meta_gen #(.P_PORT_ID(PID), .P_TS_W(64)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_pe_conf_mac(MAC),
    .i_data_valid(in_vld), .i_data(in_dat), .i_alf(alf),
    .o_data_valid(out_vld), .o_data(out_dat), .o_meta_valid(meta_vld),
    .o_meta(meta), .o_pkt_cnt(pkt_cnt), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Packet-level reference model: in_pkt = forwarding a packet, absorbing = discarding to next tail.
  bit           in_pkt = 0, absorbing = 0;
  int           m_flits;
  bit           m_disc, m_conf;
  logic [63:0]  m_ts, ts_ctr;
  bit           exp_dv, exp_mv;
  logic [133:0] exp_data;
  logic [167:0] exp_meta;
  logic [31:0]  exp_pkt, exp_drop;

  task automatic model_reset();
    in_pkt = 0; absorbing = 0; ts_ctr = 0; exp_dv = 0; exp_mv = 0;
    exp_data = '0; exp_meta = '0; exp_pkt = 0; exp_drop = 0;
  endtask

  task automatic emit(input int n, input int nb, input bit err);
    int len;
    len = 16 * (n - 1) + nb + 1;
    if (len > 65535) len = 65535;
    if (n > 65535) n = 65535;
    exp_meta = '0;
    exp_meta[167:160] = PID;
    exp_meta[159:144] = 16'(len);
    exp_meta[143:128] = 16'(n);
    exp_meta[118] = m_disc | err;
    exp_meta[117] = err;
    exp_meta[116] = m_conf;
    exp_meta[63:0] = m_ts;
    exp_mv = 1;
    exp_pkt = exp_pkt + 1;
  endtask

  task automatic model_step();
    logic [1:0]  tg;
    logic [47:0] dst;
    bit          conf;
    if (!rst_n) begin model_reset(); return; end
    exp_dv = 0; exp_mv = 0;
    if (in_vld) begin
      tg = in_dat[133:132];
      dst = in_dat[127:80];
      conf = (in_dat[31:16] == 16'h9005);
      if (tg == H && in_pkt) begin
        exp_dv = 1; exp_data = {T, in_dat[131:0]};
        emit(m_flits + 1, int'(in_dat[131:128]), 1);
        in_pkt = 0; absorbing = 1;
      end else if (tg == H) begin
        if (!alf || conf) begin
          in_pkt = 1; absorbing = 0; m_flits = 1;
          m_disc = (dst != MAC) && (dst != BC); m_conf = conf; m_ts = ts_ctr;
          exp_dv = 1; exp_data = in_dat;
        end else begin
          exp_drop = exp_drop + 1; absorbing = 1;
        end
      end else if (in_pkt) begin
        exp_dv = 1; exp_data = in_dat;
        if (tg == T) begin emit(m_flits + 1, int'(in_dat[131:128]), 0); in_pkt = 0; end
        else m_flits++;
      end else if (absorbing) begin
        if (tg == T) absorbing = 0;
      end else begin
        exp_drop = exp_drop + 1;
        absorbing = (tg != T);
      end
    end
    ts_ctr = ts_ctr + 1;
  endtask

  int           out_flits = 0, meta_events = 0;
  logic [167:0] last_meta;
  logic [1:0]   last_tag;

  task automatic check_cycle();
    if (!rst_n) begin
      chk("rst_data_valid", out_vld, 0);
      chk("rst_data", out_dat, 0);
      chk("rst_meta_valid", meta_vld, 0);
      chk("rst_meta", meta, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
    end else begin
      chk("data_valid", out_vld, exp_dv);
      if (exp_dv) chk("data", out_dat, exp_data);
      chk("meta_valid", meta_vld, exp_mv);
      chk("meta", meta, exp_meta);
      chk("pkt_cnt", pkt_cnt, exp_pkt);
      chk("drop_cnt", drop_cnt, exp_drop);
    end
    if (out_vld === 1'b1) out_flits++;
    if (meta_vld === 1'b1) begin
      meta_events++; last_meta = meta; last_tag = out_dat[133:132];
    end
  endtask

  // Called just after a falling edge: drive, clock, model, check.
  task automatic step(input bit v, input logic [133:0] d, input bit a);
    in_vld = v; in_dat = d; alf = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  function automatic logic [133:0] head(input logic [47:0] dst, input logic [15:0] et);
    return {H, 4'h0, dst, 48'h0A0B_0C0D_0E0F, et, 16'h1234};
  endfunction

  function automatic logic [133:0] flit(input logic [1:0] tg, input logic [3:0] nb);
    return {tg, nb, $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_pkt(input logic [47:0] dst, input logic [15:0] et, input int n,
                          input logic [3:0] nb, input bit alf_head, input bit alf_rest, input bit gap);
    step(1, head(dst, et), alf_head);
    for (int i = 1; i < n; i++) begin
      if (gap && i == 1) step(0, '0, alf_rest);
      step(1, flit((i == n - 1) ? T : B, (i == n - 1) ? nb : 4'h0), alf_rest);
    end
    step(0, '0, 0);
    step(0, '0, 0);
  endtask

  typedef struct {
    logic [47:0] dst; logic [15:0] et; int n; logic [3:0] nb; bit alf;
    bit fwd; logic [15:0] len; bit disc; bit conf;
  } vec_t;

  vec_t tbl[6];
  int   me0, dr0, of0;

  initial begin
    tbl[0] = '{MAC, 16'h0800, 4, 4'd3,  0, 1, 16'd52, 0, 0};
    tbl[1] = '{FOR, 16'h0800, 2, 4'd15, 0, 1, 16'd32, 1, 0};
    tbl[2] = '{BC,  16'h0806, 3, 4'd0,  0, 1, 16'd33, 0, 0};
    tbl[3] = '{MAC, 16'h0800, 3, 4'd5,  1, 0, 16'd0,  0, 0};
    tbl[4] = '{FOR, 16'h9005, 2, 4'd7,  1, 1, 16'd24, 1, 1};
    tbl[5] = '{MAC, 16'h86DD, 5, 4'd15, 0, 1, 16'd80, 0, 0};

    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    rst_n = 1;
    step(0, '0, 0);

    for (int i = 0; i < 6; i++) begin
      me0 = meta_events; dr0 = drop_cnt; of0 = out_flits;
      send_pkt(tbl[i].dst, tbl[i].et, tbl[i].n, tbl[i].nb, tbl[i].alf, 0, 0);
      chk("tbl_fwd_flits", 32'(out_flits - of0), tbl[i].fwd ? tbl[i].n : 0);
      chk("tbl_drop_delta", 32'(drop_cnt - dr0), tbl[i].fwd ? 0 : 1);
      chk("tbl_meta_events", 32'(meta_events - me0), tbl[i].fwd ? 1 : 0);
      if (tbl[i].fwd) begin
        chk("tbl_len", last_meta[159:144], tbl[i].len);
        chk("tbl_flits", last_meta[143:128], 16'(tbl[i].n));
        chk("tbl_disc", last_meta[118], tbl[i].disc);
        chk("tbl_conf", last_meta[116], tbl[i].conf);
        chk("tbl_err", last_meta[117], 0);
        chk("tbl_port", last_meta[167:160], PID);
      end
    end
    chk("tbl_pkt_cnt", pkt_cnt, 5);

    // alf rising mid-packet, with a gap inside the packet
    me0 = meta_events;
    send_pkt(MAC, 16'h0800, 4, 4'd9, 0, 1, 1);
    chk("alf_mid_meta", 32'(meta_events - me0), 1);
    chk("alf_mid_len", last_meta[159:144], 16'd58);

    // truncation: head, body, second head then its body/tail absorbed
    of0 = out_flits; me0 = meta_events;
    step(1, head(MAC, 16'h0800), 0);
    step(1, flit(B, 4'h0), 0);
    step(1, head(BC, 16'h0800), 0);
    step(1, flit(B, 4'h0), 0);
    step(1, flit(T, 4'h2), 0);
    step(0, '0, 0);
    chk("trunc_flits", 32'(out_flits - of0), 3);
    chk("trunc_meta", 32'(meta_events - me0), 1);
    chk("trunc_tag", last_tag, T);
    chk("trunc_err_disc", last_meta[118:117], 2'b11);

    // orphan run
    of0 = out_flits; dr0 = drop_cnt;
    step(1, flit(B, 4'h0), 0);
    step(1, flit(B, 4'h0), 0);
    step(1, flit(T, 4'h1), 0);
    step(0, '0, 0);
    chk("orphan_out", 32'(out_flits - of0), 0);
    chk("orphan_drop", 32'(drop_cnt - dr0), 1);

    // long packet: length saturates, flit count does not
    send_pkt(FOR, 16'h0800, 4100, 4'd15, 0, 0, 0);
    chk("sat_len", last_meta[159:144], 16'hFFFF);
    chk("sat_flits", last_meta[143:128], 16'd4100);

    // reset mid-packet, remaining flits become an orphan run
    step(1, head(MAC, 16'h0800), 0);
    step(1, flit(B, 4'h0), 0);
    rst_n = 0;
    #1;
    chk("rst_async_valid", out_vld, 0);
    chk("rst_async_cnt", pkt_cnt, 0);
    model_reset();
    step(0, '0, 0);
    step(0, '0, 0);
    rst_n = 1;
    step(1, flit(B, 4'h0), 0);
    step(1, flit(T, 4'h4), 0);
    step(0, '0, 0);
    chk("post_rst_drop", drop_cnt, 1);
    send_pkt(MAC, 16'h0800, 3, 4'd5, 0, 0, 0);
    chk("post_rst_len", last_meta[159:144], 16'd38);
    chk("post_rst_pkt", pkt_cnt, 1);

    // random flit stream
    for (int i = 0; i < 1500; i++) begin
      logic [133:0] d;
      logic [1:0]   tg;
      logic [47:0]  dst;
      int r;
      r = $urandom_range(0, 9);
      tg = (r < 3) ? H : (r < 7) ? B : T;
      r = $urandom_range(0, 2);
      dst = (r == 0) ? MAC : (r == 1) ? BC : {$urandom(), 16'h0}; 
      d = flit(tg, 4'($urandom()));
      d[127:80] = dst;
      if ($urandom_range(0, 3) == 0) d[31:16] = 16'h9005;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0);
    end
    step(0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
